// File: rtl/motor_cmd_pkg.sv
// Shared types and constants for the motor command sequencer.
// Optional broadcast frames: MOTOR_CMD_BROADCAST_EN.
package motor_cmd_pkg;

  localparam logic [2:0] HDR_PREFIX = 3'b101;
  localparam int NUM_MOTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] prefix;
    logic       bcast;
    logic [1:0] id;
    logic       dir;
    logic       en;
  } hdr_t;

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// Received-byte stream from the UART into the sequencer.
// The master drives bytes, the slave consumes them.
interface motor_cmd_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_perr;

  modport master (output rx_data, output rx_valid, output rx_perr);
  modport slave  (input  rx_data, input  rx_valid, input  rx_perr);
endinterface

// File: rtl/motor_ramp_channel.sv
// One motor: stored command, duty slew toward target, safe reversal.
// Direction flips only once the duty has been ramped to zero.
module motor_ramp_channel #(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic              cmd_en,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_tgt,
  input  logic              force_zero,
  output logic [DUTY_W-1:0] duty,
  output logic              dir,
  output logic              en
);

  logic [DUTY_W-1:0] tgt, tgt_n, eff, duty_n;
  logic              rdir, rdir_n, dir_c, dir_n, en_n;

  always_comb begin
    tgt_n  = tgt;
    rdir_n = rdir;
    if (load) begin
      tgt_n  = cmd_en ? cmd_tgt : '0;
      rdir_n = cmd_dir;
    end else if (force_zero) begin
      tgt_n = '0;
    end
    dir_c = (load && duty == '0) ? cmd_dir : dir;
    // a pending reversal first drains the duty to zero
    eff = (rdir_n != dir_c) ? '0 : tgt_n;
    duty_n = duty;
    if (tick) begin
      if (duty < eff)
        duty_n = duty + 1'b1;
      else if (duty > eff)
        duty_n = duty - 1'b1;
    end
    dir_n = dir_c;
    if (tick && duty_n == '0 && rdir_n != dir_c)
      dir_n = rdir_n;
    en_n = en;
    if (load && cmd_en)
      en_n = 1'b1;
    else if (duty_n == '0 && tgt_n == '0)
      en_n = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt  <= '0;
      rdir <= 1'b0;
      duty <= '0;
      dir  <= 1'b0;
      en   <= 1'b0;
    end else begin
      tgt  <= tgt_n;
      rdir <= rdir_n;
      duty <= duty_n;
      dir  <= dir_n;
      en   <= en_n;
    end
  end

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Frame parser, inter-byte timer, ramp prescaler and link watchdog.
// MOTOR_CMD_BROADCAST_EN enables bcast headers to all motors.
module motor_cmd_sequencer
  import motor_cmd_pkg::*;
#(
  parameter int DUTY_W     = 8,
  parameter int RAMP_DIV   = 5000,
  parameter int IBYTE_TMO  = 50000,
  parameter int WDT_CYCLES = 25000000
) (
  input  logic                           clk,
  input  logic                           reset,
  motor_cmd_sequencer_if.slave           rx,
  output logic [NUM_MOTORS-1:0]          m_en,
  output logic [NUM_MOTORS-1:0]          m_dir,
  output logic [NUM_MOTORS*DUTY_W-1:0]   m_duty,
  output logic                           cmd_ack,
  output logic                           frame_err,
  output logic                           wdt_trip
);

`ifdef MOTOR_CMD_BROADCAST_EN
  localparam bit BCAST_OK = 1'b1;
`else
  localparam bit BCAST_OK = 1'b0;
`endif

  localparam int IB_W = $clog2(IBYTE_TMO + 1);
  localparam int RD_W = $clog2(RAMP_DIV + 1);
  localparam int WD_W = $clog2(WDT_CYCLES + 1);

  state_t            state;
  logic [4:0]        hdr_q;
  logic [DUTY_W-1:0] tgt_q;
  logic [IB_W-1:0]   ib_cnt;
  logic [RD_W-1:0]   rd_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic              tick, apply, expire;
  hdr_t              hdr_in;

  assign hdr_in = hdr_t'(rx.rx_data);
  assign apply  = (state == ST_APPLY);
  assign tick   = (rd_cnt == RD_W'(RAMP_DIV - 1));
  // apply beats a coincident expiry
  assign expire = (wd_cnt == WD_W'(WDT_CYCLES - 1)) && !apply;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hdr_q     <= '0;
      tgt_q     <= '0;
      ib_cnt    <= '0;
      cmd_ack   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_ack   <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (rx.rx_valid) begin
            if (rx.rx_perr || hdr_in.prefix != HDR_PREFIX ||
                (hdr_in.bcast && !BCAST_OK)) begin
              frame_err <= 1'b1;
            end else begin
              hdr_q  <= rx.rx_data[4:0];
              ib_cnt <= '0;
              state  <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (rx.rx_valid) begin
            if (rx.rx_perr) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              tgt_q   <= rx.rx_data[DUTY_W-1:0];
              cmd_ack <= 1'b1;
              state   <= ST_APPLY;
            end
          end else if (ib_cnt == IB_W'(IBYTE_TMO - 1)) begin
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            ib_cnt <= ib_cnt + 1'b1;
          end
        end
        ST_APPLY: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_cnt <= '0;
    end else if (tick) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      wdt_trip <= 1'b0;
    end else begin
      if (apply) begin
        wd_cnt   <= '0;
        wdt_trip <= 1'b0;
      end else if (wd_cnt != WD_W'(WDT_CYCLES)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (expire)
        wdt_trip <= 1'b1;
    end
  end

  for (genvar n = 0; n < NUM_MOTORS; n++) begin : g_ch
    logic sel;
    assign sel = apply && ((BCAST_OK && hdr_q[4]) || hdr_q[3:2] == 2'(n));
    motor_ramp_channel #(.DUTY_W(DUTY_W)) u_ch (
      .clk        (clk),
      .rst_n      (reset),
      .tick       (tick),
      .load       (sel),
      .cmd_en     (hdr_q[0]),
      .cmd_dir    (hdr_q[1]),
      .cmd_tgt    (tgt_q),
      .force_zero (expire),
      .duty       (m_duty[n*DUTY_W +: DUTY_W]),
      .dir        (m_dir[n]),
      .en         (m_en[n])
    );
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed bench for motor_cmd_sequencer with short timing parameters.
// Define MOTOR_CMD_BROADCAST_EN to exercise broadcast frames.
module tb_motor_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  m_en, m_dir;
  logic [31:0] m_duty;
  logic        cmd_ack, frame_err, wdt_trip;
  int          total = 0;
  int          bad = 0;
  int          n;
  int          errs;

  motor_cmd_sequencer_if rx_bus();

  motor_cmd_sequencer #(
    .DUTY_W(8), .RAMP_DIV(4), .IBYTE_TMO(20), .WDT_CYCLES(400)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_bus.slave),
    .m_en      (m_en),
    .m_dir     (m_dir),
    .m_duty    (m_duty),
    .cmd_ack   (cmd_ack),
    .frame_err (frame_err),
    .wdt_trip  (wdt_trip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic perr);
    @(negedge clk);
    rx_bus.rx_data  = b;
    rx_bus.rx_valid = 1'b1;
    rx_bus.rx_perr  = perr;
    @(posedge clk);
    #1;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_perr  = 1'b0;
  endtask

  task automatic wait_duty(input int m, input logic [7:0] v,
                           input int lim, input string tag);
    int k;
    k = 0;
    while (m_duty[m*8 +: 8] !== v && k < lim) begin
      cyc(1);
      k++;
    end
    chk(tag, {24'h0, m_duty[m*8 +: 8]}, {24'h0, v});
  endtask

  initial begin
    rx_bus.rx_data  = 8'h00;
    rx_bus.rx_valid = 1'b0;
    rx_bus.rx_perr  = 1'b0;
    cyc(3);
    chk("rst_en", m_en, 0);
    chk("rst_duty", m_duty, 0);
    reset = 1'b1;
    cyc(2);
    chk("rst_dir", m_dir, 0);
    chk("rst_flags", {cmd_ack, frame_err, wdt_trip}, 0);

    // header then reset: no pulses, header forgotten
    send(8'hA3, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1);
    chk("midrst_flags", {cmd_ack, frame_err}, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk("midrst_flags2", {cmd_ack, frame_err}, 0);
    send(8'h40, 1'b0);
    chk("midrst_err", frame_err, 1);
    chk("midrst_noack", cmd_ack, 0);

    // motor0 forward to 0x40
    send(8'hA3, 1'b0);
    chk("hdr_noerr", frame_err, 0);
    send(8'h40, 1'b0);
    chk("a3_ack", cmd_ack, 1);
    cyc(1);
    chk("a3_ack_one", cmd_ack, 0);
    chk("a3_en", m_en, 4'b0001);
    chk("a3_dir", m_dir, 4'b0001);
    wait_duty(0, 8'h40, 300, "a3_ramp");
    cyc(20);
    chk("a3_hold", m_duty, 32'h40);

    // reversal: drain, flip at zero, climb back
    send(8'hA1, 1'b0);
    send(8'h40, 1'b0);
    chk("a1_ack", cmd_ack, 1);
    cyc(5);
    chk("a1_dir_kept", m_dir[0], 1);
    wait_duty(0, 8'h00, 400, "rev_zero");
    chk("rev_dir_flip", m_dir[0], 0);
    chk("rev_en", m_en[0], 1);
    send(8'hA1, 1'b0);
    send(8'h40, 1'b0);
    chk("keep_ack", cmd_ack, 1);
    wait_duty(0, 8'h40, 400, "rev_climb");
    chk("rev_dir_fin", m_dir[0], 0);
    chk("rev_en_fin", m_en[0], 1);

    // inter-byte timeout then orphan data byte
    send(8'hA3, 1'b0);
    errs = 0;
    for (int i = 0; i < 21; i++) begin
      cyc(1);
      if (frame_err === 1'b1) errs++;
    end
    chk("tmo_err", errs, 1);
    send(8'h40, 1'b0);
    chk("tmo_orphan_err", frame_err, 1);

    // parity errors on data and header
    send(8'hA3, 1'b0);
    send(8'h10, 1'b1);
    chk("perr_err", frame_err, 1);
    chk("perr_noack", cmd_ack, 0);
    cyc(10);
    chk("perr_nochg", {m_dir[0], m_duty[7:0]}, {1'b0, 8'h40});
    send(8'hA3, 1'b1);
    chk("perr_hdr", frame_err, 1);

    // motor2 to 0x10, then link silence
    send(8'hAB, 1'b0);
    send(8'h10, 1'b0);
    chk("ab_ack", cmd_ack, 1);
    wait_duty(2, 8'h10, 100, "ab_ramp");
    n = 0;
    while (wdt_trip !== 1'b1 && n < 450) begin
      cyc(1);
      n++;
    end
    chk("wdt_trip", wdt_trip, 1);
    chk("wdt_nostep", m_duty[23:16] >= 8'h0F, 1);
    wait_duty(2, 8'h00, 100, "wdt_zero");
    chk("wdt_en2", m_en[2], 0);
    chk("wdt_held", wdt_trip, 1);
    send(8'hAB, 1'b0);
    send(8'h20, 1'b0);
    chk("wdt_ack", cmd_ack, 1);
    cyc(1);
    chk("wdt_clear", wdt_trip, 0);
    chk("wdt_en2_re", m_en[2], 1);

    // broadcast header
    send(8'hB3, 1'b0);
`ifdef MOTOR_CMD_BROADCAST_EN
    chk("bc_hdr", frame_err, 0);
    send(8'h30, 1'b0);
    chk("bc_ack", cmd_ack, 1);
    cyc(1);
    chk("bc_en", m_en, 4'b1111);
    wait_duty(3, 8'h30, 300, "bc_duty3");
    wait_duty(1, 8'h30, 20, "bc_duty1");
`else
    chk("bc_rej", frame_err, 1);
    send(8'h30, 1'b0);
    chk("bc_data_err", frame_err, 1);
    chk("bc_noack", cmd_ack, 0);
    cyc(2);
    chk("bc_nochg", {m_en[3], m_en[1], m_duty[31:24], m_duty[15:8]}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
